// File: rtl/fetch_unit.sv
// LC-3b instruction fetch stage: owns the fetch PC, issues single-word reads and queues {pc+2, instr} for decode.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_read,
    output logic [15:0] mem_address,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
`ifdef FETCH_PERF_EN
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_flushed,
`endif
    output logic [15:0] out_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        state;
    logic [15:0]   fetch_pc;
    logic [15:0]   req_addr;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [15:0]   q_pc    [DEPTH];
    logic [15:0]   q_instr [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] count_post;
    logic [15:0]   redirect_target;
    logic [15:0]   pc_inc;
    logic          unused_redirect_bit;

    // Decode valid/ready: the head moves when out_valid && out_ready, unless a
    // redirect in the same cycle flushes the queue (that pop never happened).
    assign pop             = (count != '0) && out_ready && !redirect_valid;
    assign push            = (state == REQ) && mem_resp && !redirect_valid;
    assign count_post      = count + CW'(push) - CW'(pop);
    assign redirect_target = {redirect_pc[15:1], 1'b0};
    assign pc_inc          = fetch_pc + 16'd2;
    assign unused_redirect_bit = redirect_pc[0];

    assign mem_read    = (state == REQ) || (state == DROP);
    assign mem_address = (state == DROP) ? req_addr : fetch_pc;
    assign out_valid   = (count != '0);
    assign out_instr   = q_instr[head];
    assign out_pc      = q_pc[head];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else begin
            if (redirect_valid) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    q_pc[tail]    <= pc_inc;
                    q_instr[tail] <= mem_rdata;
                    tail          <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                count <= count_post;
            end

            // DROP keeps the old address on the bus until the abandoned read answers.
            case (state)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end else if (count < DEPTH_C) begin
                        state    <= REQ;
                        req_addr <= fetch_pc;
                    end
                end
                REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                        state    <= mem_resp ? IDLE : DROP;
                    end else if (mem_resp) begin
                        fetch_pc <= pc_inc;
                        req_addr <= pc_inc;
                        state    <= (count_post < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_target;
                    end
                    if (mem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic        drop_resp;
    logic [1:0]  flush_inc;
    logic [16:0] flush_sum;

    assign drop_resp = mem_resp && (((state == REQ) && redirect_valid) || (state == DROP));
    assign flush_inc = {1'b0, redirect_valid} + {1'b0, drop_resp};
    assign flush_sum = {1'b0, perf_flushed} + {15'd0, flush_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && (perf_fetched != 16'hFFFF)) begin
                perf_fetched <= perf_fetched + 16'd1;
            end
            perf_flushed <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus a randomized phase, scored against
// a queue-based model of the fetch/deliver rules.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;

    logic        m2_read;
    logic [15:0] m2_address;
    logic        m2_resp;
    logic [15:0] m2_rdata;
    logic        m2_valid;
    logic        m2_ready;
    logic [15:0] m2_instr;
    logic [15:0] m2_pc;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
    logic [15:0] m2_perf_fetched;
    logic [15:0] m2_perf_flushed;
`endif

    fetch_unit #(.RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_resp       (mem_resp),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed),
`endif
        .out_pc         (out_pc)
    );

    fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(4)) dut2 (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (m2_read),
        .mem_address    (m2_address),
        .mem_resp       (m2_resp),
        .mem_rdata      (m2_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (16'h0000),
        .out_valid      (m2_valid),
        .out_ready      (m2_ready),
        .out_instr      (m2_instr),
`ifdef FETCH_PERF_EN
        .perf_fetched   (m2_perf_fetched),
        .perf_flushed   (m2_perf_flushed),
`endif
        .out_pc         (m2_pc)
    );

    // Clock / reset generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard and reference model state
    int          n_checks;
    int          n_fail;
    ent_t        exp_q[$];
    logic [15:0] issues[$];
    logic [15:0] pop_pcs[$];
    logic [15:0] pop_instrs[$];
    logic [15:0] exp_fetch_pc;
    bit          pending;
    bit          pend_drop;
    logic [15:0] pend_addr;
    int          pend_left;
    bit          prev_redirect;
    int          fixed_lat;
    bit          redir_on_resp;
    logic [15:0] redir_on_resp_tgt;
    int          total_delivered;
    int          perf_f_m;
    int          perf_x_m;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h1234;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        issues.delete();
        pop_pcs.delete();
        pop_instrs.delete();
        exp_fetch_pc  = 16'h0000;
        pending       = 1'b0;
        pend_drop     = 1'b0;
        prev_redirect = 1'b0;
        redir_on_resp = 1'b0;
        perf_f_m      = 0;
        perf_x_m      = 0;
    endtask

    // Called at a falling edge: asynchronous reset mid-cycle, then release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mem_read", 16'(mem_read), 16'h0);
        chk("rst_mem_address", mem_address, 16'h0000);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_instr", out_instr, 16'h0000);
        chk("rst_out_pc", out_pc, 16'h0000);
        chk("rst2_mem_address", m2_address, 16'hFFFE);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 16'h0);
        chk("rst_perf_flushed", perf_flushed, 16'h0);
`endif
        mem_resp       = 1'b0;
        mem_rdata      = 16'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0;
        out_ready      = 1'b0;
        m2_resp        = 1'b0;
        m2_rdata       = 16'h0;
        m2_ready       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("first_read", 16'(mem_read), 16'h1);
        chk("first_addr", mem_address, 16'h0000);
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input int ready_mode, input bit redir_in, input logic [15:0] tgt_in);
        bit          resp_now;
        bit          redir;
        bit          pop;
        bit          push;
        logic [15:0] tgt;
        ent_t        e;

        chk("out_valid", 16'(out_valid), 16'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_instr", out_instr, exp_q[0].instr);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 16'(perf_f_m));
        chk("perf_flushed", perf_flushed, 16'(perf_x_m));
`endif

        resp_now = 1'b0;
        if (!pending) begin
            if (prev_redirect) chk("no_issue_after_redirect", 16'(mem_read), 16'h0);
            if (mem_read) begin
                chk("issue_addr", mem_address, exp_fetch_pc);
                chk("issue_room", 16'(exp_q.size() < DEPTH), 16'h1);
                pending   = 1'b1;
                pend_drop = 1'b0;
                pend_addr = mem_address;
                pend_left = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
                issues.push_back(mem_address);
            end
        end else begin
            chk("hold_read", 16'(mem_read), 16'h1);
            chk("hold_addr", mem_address, pend_addr);
            pend_left--;
            resp_now = (pend_left == 0);
        end

        redir = redir_in;
        tgt   = tgt_in;
        if (redir_on_resp && resp_now) begin
            redir         = 1'b1;
            tgt           = redir_on_resp_tgt;
            redir_on_resp = 1'b0;
        end

        out_ready      = (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
        mem_resp       = resp_now;
        mem_rdata      = resp_now ? mem_word(pend_addr) : 16'($urandom);
        redirect_valid = redir;
        redirect_pc    = tgt;

        pop = (exp_q.size() != 0) && out_ready && !redir;
        if (redir && pending) pend_drop = 1'b1;
        push = resp_now && !pend_drop;
        if (redir) begin
            exp_q.delete();
            exp_fetch_pc = {tgt[15:1], 1'b0};
            perf_x_m++;
        end else begin
            if (pop) begin
                e = exp_q.pop_front();
                pop_pcs.push_back(e.pc);
                pop_instrs.push_back(e.instr);
                total_delivered++;
            end
            if (push) begin
                chk("no_overflow", 16'(exp_q.size() < DEPTH), 16'h1);
                exp_q.push_back('{pc: pend_addr + 16'd2, instr: mem_word(pend_addr)});
                exp_fetch_pc = pend_addr + 16'd2;
                perf_f_m++;
            end
        end
        if (resp_now) begin
            if (pend_drop) perf_x_m++;
            pending = 1'b0;
        end
        prev_redirect = redir;
        @(negedge clk);
    endtask

    initial begin
        int          npop;
        int          niss;
        bit          r;
        logic [15:0] tgt;
        bit          pend2;
        logic [15:0] p2_addr;
        logic [15:0] iss2[$];
        logic [15:0] pops2[$];
        logic [15:0] instr2[$];

        n_checks        = 0;
        n_fail          = 0;
        total_delivered = 0;
        fixed_lat       = 1;
        rst_n           = 1'b1;
        mem_resp        = 1'b0;
        mem_rdata       = 16'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 16'h0;
        out_ready       = 1'b0;
        m2_resp         = 1'b0;
        m2_rdata        = 16'h0;
        m2_ready        = 1'b0;
        model_reset();

        // Streaming with a 1-cycle memory and decode always ready
        do_reset();
        fixed_lat = 1;
        for (int i = 0; i < 12; i++) step(1, 1'b0, 16'h0);
        chk("a_issue0", issues[0], 16'h0000);
        chk("a_issue1", issues[1], 16'h0002);
        chk("a_issue2", issues[2], 16'h0004);
        chk("a_first_pc", pop_pcs[0], 16'h0002);
        chk("a_first_instr", pop_instrs[0], 16'h1234);

        // Backpressure: queue fills, reads stop, one pop re-issues at 0x0004
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 1'b0, 16'h0);
        chk("b_stall_read", 16'(mem_read), 16'h0);
        chk("b_stall_issues", 16'(issues.size()), 16'd2);
        step(1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) step(0, 1'b0, 16'h0);
        chk("b_reissue_count", 16'(issues.size()), 16'd3);
        if (issues.size() > 2) chk("b_reissue_addr", issues[2], 16'h0004);

        // Redirect while the read of 0x0004 is outstanding (3-cycle memory)
        do_reset();
        fixed_lat = 3;
        for (int i = 0; i < 40 && issues.size() < 3; i++) step(1, 1'b0, 16'h0);
        chk("c_reached_0004", 16'(issues.size()), 16'd3);
        if (issues.size() > 2) chk("c_issue2", issues[2], 16'h0004);
        npop = pop_pcs.size();
        step(1, 1'b1, 16'h3001);
        for (int i = 0; i < 30 && pop_pcs.size() <= npop; i++) step(1, 1'b0, 16'h0);
        chk("c_delivered", 16'(pop_pcs.size() > npop), 16'h1);
        if (issues.size() > 3) chk("c_target_issue", issues[3], 16'h3000);
        if (pop_pcs.size() > npop) chk("c_target_pc", pop_pcs[npop], 16'h3002);

        // Redirect coinciding with mem_resp and out_ready
        do_reset();
        fixed_lat = 1;
        for (int i = 0; i < 6; i++) step(1, 1'b0, 16'h0);
        redir_on_resp     = 1'b1;
        redir_on_resp_tgt = 16'h5A5A;
        for (int i = 0; i < 10 && redir_on_resp; i++) step(1, 1'b0, 16'h0);
        chk("d_redirect_done", 16'(redir_on_resp), 16'h0);
        chk("d_flushed", 16'(out_valid), 16'h0);
        niss = issues.size();
        for (int i = 0; i < 6; i++) step(1, 1'b0, 16'h0);
        chk("d_new_issue", 16'(issues.size() > niss), 16'h1);
        if (issues.size() > niss) chk("d_target_issue", issues[niss], 16'h5A5A);

        // Address wrap on the instance reset to 0xFFFE
        do_reset();
        pend2    = 1'b0;
        p2_addr  = 16'h0;
        m2_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            m2_resp = 1'b0;
            if (m2_valid) begin
                pops2.push_back(m2_pc);
                instr2.push_back(m2_instr);
            end
            if (pend2) begin
                m2_resp  = 1'b1;
                m2_rdata = mem_word(p2_addr);
                pend2    = 1'b0;
            end else if (m2_read) begin
                pend2   = 1'b1;
                p2_addr = m2_address;
                iss2.push_back(m2_address);
            end
            @(negedge clk);
        end
        m2_resp = 1'b0;
        chk("e_count", 16'((iss2.size() >= 2) && (pops2.size() >= 2)), 16'h1);
        if (iss2.size() >= 2 && pops2.size() >= 2) begin
            chk("e_issue0", iss2[0], 16'hFFFE);
            chk("e_issue1", iss2[1], 16'h0000);
            chk("e_pc0", pops2[0], 16'h0000);
            chk("e_pc1", pops2[1], 16'h0002);
            chk("e_instr0", instr2[0], mem_word(16'hFFFE));
        end

        // Randomized traffic with a reset dropped into the middle of it
        do_reset();
        fixed_lat       = 0;
        total_delivered = 0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            r   = ($urandom_range(0, 9) == 0);
            tgt = 16'($urandom);
            if ($urandom_range(0, 3) == 0) tgt = 16'hFFFC | 16'($urandom_range(0, 1));
            step(2, r, tgt);
        end
        chk("rand_liveness", 16'(total_delivered > 40), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
